// File: rtl/lmb_bram_port_arbiter.sv
// lmb_bram_port_arbiter
// Shares one LMB BRAM port between two streaming requesters (0 = ADC capture
// writer, 1 = DAC playback reader). Round-robin arbitration with a bounded
// burst lock, address range check, and a 2-stage read-tag pipeline that
// steers returned BRAM data to the requester that issued the read.
//
// Ports
//   BRAM_Clk, BRAM_Rst_N          clock, asynchronous active-low reset
//   ReqX/WeX/BeX/AddrX/WDataX     requester X access (held until AckX)
//   AckX                          combinational grant, same cycle as request
//   Rd_Data, Rd_ValidX            read return, two cycles after the grant
//   Err                           one-cycle pulse for an out-of-range access
//   BRAM_EN/WEN/Addr/Dout         registered BRAM port drive
//   BRAM_Din                      BRAM read data, one cycle after EN
//
// Bus vectors are numbered [W-1:0] with their numeric value preserved, so
// BRAM-style bits [30:31] are the two address LSBs here.
module lmb_bram_port_arbiter #(
  parameter int unsigned C_MEMSIZE     = 32'h0001_0000,
  parameter int unsigned C_BASEADDR    = 32'h0000_0000,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4,
  parameter int unsigned C_MAX_BURST   = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     Req0,
  input  logic                     Req1,
  input  logic                     We0,
  input  logic                     We1,
  input  logic [C_NUM_WE-1:0]      Be0,
  input  logic [C_NUM_WE-1:0]      Be1,
  input  logic [C_PORT_AWIDTH-1:0] Addr0,
  input  logic [C_PORT_AWIDTH-1:0] Addr1,
  input  logic [C_PORT_DWIDTH-1:0] WData0,
  input  logic [C_PORT_DWIDTH-1:0] WData1,
  output logic                     Ack0,
  output logic                     Ack1,
  output logic [C_PORT_DWIDTH-1:0] Rd_Data,
  output logic                     Rd_Valid0,
  output logic                     Rd_Valid1,
  output logic                     Err,
  output logic                     BRAM_EN,
  output logic [C_NUM_WE-1:0]      BRAM_WEN,
  output logic [C_PORT_AWIDTH-1:0] BRAM_Addr,
  output logic [C_PORT_DWIDTH-1:0] BRAM_Dout,
  input  logic [C_PORT_DWIDTH-1:0] BRAM_Din
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0]         MAX_CNT    = CNT_W'(C_MAX_BURST);
  localparam logic [C_PORT_AWIDTH-1:0] BASE       = C_PORT_AWIDTH'(C_BASEADDR);
  localparam logic [C_PORT_AWIDTH-1:0] SIZE       = C_PORT_AWIDTH'(C_MEMSIZE);
  localparam logic [C_PORT_AWIDTH-1:0] ALIGN_MASK = ~C_PORT_AWIDTH'(3);

  // Arbitration state
  logic             r_last_grant;
  logic [CNT_W-1:0] r_burst_cnt;

  // Issue stage registers
  logic                     r_en;
  logic [C_NUM_WE-1:0]      r_wen;
  logic [C_PORT_AWIDTH-1:0] r_addr;
  logic [C_PORT_DWIDTH-1:0] r_dout;
  logic                     r_err;

  // Read-tag pipeline: stage 1 alongside the issue, stage 2 alongside the return
  logic r_t1_vld;
  logic r_t1_id;
  logic r_t1_oor;
  logic r_rv0;
  logic r_rv1;
  logic r_rd_oor;

  logic                     w_grant0;
  logic                     w_grant1;
  logic                     w_any;
  logic                     w_keep;
  logic                     w_we;
  logic [C_NUM_WE-1:0]      w_be;
  logic [C_PORT_AWIDTH-1:0] w_addr;
  logic [C_PORT_DWIDTH-1:0] w_wdata;
  logic                     w_in_range;

  // Grant decision. The owner keeps a contended port only while a burst is
  // live (count non-zero) and below the cap; an idle gap or a full burst
  // hands the tie to the other side, so requester 0 wins the first tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    w_keep   = (r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT);
    if (Req0 && Req1) begin
      if (w_keep) begin
        w_grant0 = ~r_last_grant;
        w_grant1 = r_last_grant;
      end else begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end
    end else begin
      w_grant0 = Req0;
      w_grant1 = Req1;
    end
  end

  // Granted access mux and range check (unsigned, wraps at address width)
  always_comb begin
    w_any      = w_grant0 | w_grant1;
    w_we       = w_grant1 ? We1    : We0;
    w_be       = w_grant1 ? Be1    : Be0;
    w_addr     = w_grant1 ? Addr1  : Addr0;
    w_wdata    = w_grant1 ? WData1 : WData0;
    w_in_range = (w_addr - BASE) < SIZE;
  end

  // Burst counter and round-robin owner
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_last_grant <= 1'b1;
      r_burst_cnt  <= '0;
    end else if (w_any) begin
      if (w_grant1 == r_last_grant) begin
        if (r_burst_cnt < MAX_CNT) begin
          r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end
      end else begin
        r_burst_cnt  <= CNT_W'(1);
        r_last_grant <= w_grant1;
      end
    end else begin
      r_burst_cnt <= '0;
    end
  end

  // BRAM issue stage; Addr/Dout hold across idle cycles
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_en   <= 1'b0;
      r_wen  <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      r_en  <= w_any & w_in_range;
      r_wen <= (w_any && w_in_range && w_we) ? w_be : '0;
      r_err <= w_any & ~w_in_range;
      if (w_any) begin
        r_addr <= w_addr & ALIGN_MASK;
        r_dout <= w_wdata;
      end
    end
  end

  // Read tags; out-of-range reads still return so the requester never hangs
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      r_t1_vld <= 1'b0;
      r_t1_id  <= 1'b0;
      r_t1_oor <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
      r_rd_oor <= 1'b0;
    end else begin
      r_t1_vld <= w_any & ~w_we;
      r_t1_id  <= w_grant1;
      r_t1_oor <= ~w_in_range;
      r_rv0    <= r_t1_vld & ~r_t1_id;
      r_rv1    <= r_t1_vld & r_t1_id;
      r_rd_oor <= r_t1_oor;
    end
  end

  assign Ack0      = w_grant0;
  assign Ack1      = w_grant1;
  assign BRAM_EN   = r_en;
  assign BRAM_WEN  = r_wen;
  assign BRAM_Addr = r_addr;
  assign BRAM_Dout = r_dout;
  assign Err       = r_err;
  assign Rd_Valid0 = r_rv0;
  assign Rd_Valid1 = r_rv1;
  // BRAM_Din is only meaningful in the return cycle of an in-range read
  assign Rd_Data   = ((r_rv0 || r_rv1) && !r_rd_oor) ? BRAM_Din : '0;

endmodule

// File: tb/tb_lmb_bram_port_arbiter.sv
// Bench for lmb_bram_port_arbiter: hand sequences, a grant-order vector table
// and randomized two-requester traffic checked against a behavioural model.
module tb_lmb_bram_port_arbiter;

  localparam int unsigned MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  be0 = '0, be1 = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, rv0, rv1, err, en;
  logic [31:0] rd_data, baddr, dout;
  logic [3:0]  wen;
  logic [31:0] din = '0;

  int n_checks = 0;
  int n_errors = 0;

  lmb_bram_port_arbiter #(
    .C_MEMSIZE(32'h0001_0000), .C_BASEADDR(32'h0), .C_PORT_DWIDTH(32),
    .C_PORT_AWIDTH(32), .C_NUM_WE(4), .C_MAX_BURST(MAXB)
  ) dut (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .Req0(req0), .Req1(req1), .We0(we0), .We1(we1), .Be0(be0), .Be1(be1),
    .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
    .Ack0(ack0), .Ack1(ack1), .Rd_Data(rd_data),
    .Rd_Valid0(rv0), .Rd_Valid1(rv1), .Err(err),
    .BRAM_EN(en), .BRAM_WEN(wen), .BRAM_Addr(baddr), .BRAM_Dout(dout),
    .BRAM_Din(din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Simple BRAM: read-first, one-cycle read latency
  logic [31:0] mem [0:16383];
  initial for (int i = 0; i < 16384; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (en) begin
      din <= mem[baddr[15:2]];
      for (int k = 0; k < 4; k++)
        if (wen[k]) mem[baddr[15:2]][8*k +: 8] <= dout[8*k +: 8];
    end
  end

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] dout;
    logic        err;
    logic        rv0;
    logic        rv1;
    logic [31:0] rdata;
  } exp_t;

  int          hist[$];               // granted id per cycle, -1 = no grant
  logic [31:0] ref_mem [int unsigned];
  exp_t        iss_exp, ret_exp, nxt;

  // Tie winner from grant history: stay with the most recent grantee only if
  // it was granted last cycle and its unbroken run is still below the cap.
  function automatic int model_grant(input logic r0, input logic r1);
    int  last_id = 1;
    int  run = 0;
    bit  prev;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i] >= 0) begin last_id = hist[i]; break; end
    prev = (hist.size() > 0) && (hist[hist.size() - 1] >= 0);
    if (prev)
      for (int i = hist.size() - 1; i >= 0 && hist[i] == last_id; i--) run++;
    if (prev && run < int'(MAXB)) return last_id;
    return 1 - last_id;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  always @(negedge clk) begin
    int          g;
    logic [31:0] a, wd, w;
    logic [3:0]  b;
    logic        wr, inr;
    int unsigned idx;
    if (!rst_n) begin
      hist.delete();
      iss_exp = '0;
      ret_exp = '0;
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_wen", 32'(wen), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rv0", 32'(rv0), 32'h0);
      chk("rst_rv1", 32'(rv1), 32'h0);
    end else begin
      g = model_grant(req0, req1);
      chk("m_ack0", 32'(ack0), 32'(g == 0));
      chk("m_ack1", 32'(ack1), 32'(g == 1));
      chk("m_en", 32'(en), 32'(iss_exp.en));
      chk("m_wen", 32'(wen), 32'(iss_exp.wen));
      chk("m_err", 32'(err), 32'(iss_exp.err));
      if (iss_exp.en) begin
        chk("m_addr", baddr, iss_exp.addr);
        chk("m_dout", dout, iss_exp.dout);
      end
      chk("m_rv0", 32'(rv0), 32'(ret_exp.rv0));
      chk("m_rv1", 32'(rv1), 32'(ret_exp.rv1));
      if (ret_exp.rv0 || ret_exp.rv1) chk("m_rdata", rd_data, ret_exp.rdata);
      nxt = '0;
      if (g >= 0) begin
        a   = (g == 1) ? addr1 : addr0;
        wd  = (g == 1) ? wdata1 : wdata0;
        b   = (g == 1) ? be1 : be0;
        wr  = (g == 1) ? we1 : we0;
        inr = (a - 32'h0) < 32'h0001_0000;
        idx = (a - 32'h0) / 4;
        nxt.en   = inr;
        nxt.wen  = (inr && wr) ? b : 4'h0;
        nxt.addr = a - (a % 4);
        nxt.dout = wd;
        nxt.err  = !inr;
        nxt.rv0  = !wr && g == 0;
        nxt.rv1  = !wr && g == 1;
        nxt.rdata = inr ? ref_rd(idx) : 32'h0;
        if (inr && wr) begin
          w = ref_rd(idx);
          for (int k = 0; k < 4; k++) if (b[k]) w[8*k +: 8] = wd[8*k +: 8];
          ref_mem[idx] = w;
        end
      end
      hist.push_back(g);
      if (hist.size() > 40) void'(hist.pop_front());
      ret_exp = iss_exp;
      iss_exp = nxt;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { bit r0; bit r1; bit a0; bit a1; } vec_t;
  vec_t tbl[$];

  function automatic void add_vec(input bit r0, input bit r1, input bit a0, input bit a1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned s;
    s = $urandom_range(0, 20);
    if (s < 16) return 32'($urandom_range(0, 255));
    if (s < 18) return 32'h0001_0000 + 32'($urandom_range(0, 255));
    if (s < 20) return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    return 32'h0000_FFFC | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit prev_any;
    bit a0s, a1s;

    // Reset release, idle
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_en", 32'(en), 0);   chk("idle_wen", 32'(wen), 0);
    chk("idle_addr", baddr, 0);   chk("idle_dout", dout, 0);
    chk("idle_rv0", 32'(rv0), 0); chk("idle_rv1", 32'(rv1), 0);
    chk("idle_err", 32'(err), 0); chk("idle_ack0", 32'(ack0), 0);
    chk("idle_ack1", 32'(ack1), 0);

    // Requester 0 write
    step();
    req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    @(negedge clk); chk("wr_ack0", 32'(ack0), 1); chk("wr_ack1", 32'(ack1), 0);
    step(); req0 = 0; we0 = 0;
    @(negedge clk);
    chk("wr_en", 32'(en), 1); chk("wr_wen", 32'(wen), 32'hF);
    chk("wr_addr", baddr, 32'h10); chk("wr_dout", dout, 32'hDEADBEEF);

    // Requester 1 read back
    step(); req1 = 1; we1 = 0; addr1 = 32'h10;
    @(negedge clk); chk("rd_ack1", 32'(ack1), 1);
    step(); req1 = 0;
    @(negedge clk); chk("rd_en", 32'(en), 1); chk("rd_wen", 32'(wen), 0);
    chk("rd_addr", baddr, 32'h10);
    step();
    @(negedge clk); chk("rd_rv1", 32'(rv1), 1); chk("rd_rv0", 32'(rv0), 0);
    chk("rd_data", rd_data, 32'hDEADBEEF);

    // Out-of-range read at end of BRAM window
    step(); req1 = 1; addr1 = 32'h0001_0000;
    @(negedge clk); chk("oor_ack1", 32'(ack1), 1);
    step(); req1 = 0;
    @(negedge clk); chk("oor_err", 32'(err), 1); chk("oor_en", 32'(en), 0);
    step();
    @(negedge clk); chk("oor_rv1", 32'(rv1), 1); chk("oor_data", rd_data, 0);
    chk("oor_err_pulse", 32'(err), 0);

    // Out-of-range read at top of address space
    step(); req0 = 1; we0 = 0; addr0 = 32'hFFFF_FFFC;
    @(negedge clk); chk("top_ack0", 32'(ack0), 1);
    step(); req0 = 0;
    @(negedge clk); chk("top_err", 32'(err), 1); chk("top_en", 32'(en), 0);
    step();
    @(negedge clk); chk("top_rv0", 32'(rv0), 1); chk("top_data", rd_data, 0);

    // Reset in the issue cycle of a read drops its return
    step(); req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk); chk("rr_ack0", 32'(ack0), 1);
    step(); req0 = 0;
    chk("rr_en_pre", 32'(en), 1);
    rst_n = 0;
    #1 chk("rr_en_async", 32'(en), 0);
    step(); rst_n = 1;
    @(negedge clk); chk("rr_rv0", 32'(rv0), 0); chk("rr_rv1", 32'(rv1), 0);
    step(); req0 = 1; req1 = 1; we1 = 0; addr1 = 32'h20;
    @(negedge clk); chk("rr_tie_ack0", 32'(ack0), 1); chk("rr_tie_ack1", 32'(ack1), 0);

    // Grant-order table, starting from reset
    add_vec(1,1,1,0); add_vec(1,1,1,0); add_vec(1,1,1,0); add_vec(1,1,1,0);
    add_vec(1,1,0,1); add_vec(1,1,0,1); add_vec(1,1,0,1); add_vec(1,1,0,1);
    add_vec(1,1,1,0); add_vec(0,0,0,0); add_vec(1,1,0,1); add_vec(1,0,1,0);
    add_vec(0,1,0,1); add_vec(1,1,0,1);
    for (int i = 0; i < 10; i++) add_vec(1,0,1,0);
    add_vec(1,1,0,1);
    do_reset();
    addr0 = 32'h20; addr1 = 32'h24; we0 = 0; we1 = 0;
    prev_any = 0;
    foreach (tbl[i]) begin
      step(); req0 = tbl[i].r0; req1 = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack0", i), 32'(ack0), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_ack1", i), 32'(ack1), 32'(tbl[i].a1));
      chk($sformatf("tbl%0d_onehot", i), 32'(ack0 & ack1), 0);
      chk($sformatf("tbl%0d_en", i), 32'(en), 32'(prev_any));
      prev_any = tbl[i].a0 | tbl[i].a1;
    end
    step(); req0 = 0; req1 = 0;
    @(negedge clk); chk("tbl_last_en", 32'(en), 32'(prev_any));

    // Randomized traffic; each requester holds its request until acked
    a0s = 1; a1s = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!req0 || a0s) begin
        req0 = ($urandom_range(0, 99) < 70);
        we0 = 1'($urandom_range(0, 1)); be0 = 4'($urandom_range(0, 15));
        addr0 = rand_addr(); wdata0 = $urandom;
      end
      if (!req1 || a1s) begin
        req1 = ($urandom_range(0, 99) < 70);
        we1 = 1'($urandom_range(0, 1)); be1 = 4'($urandom_range(0, 15));
        addr1 = rand_addr(); wdata1 = $urandom;
      end
      @(negedge clk);
      a0s = ack0; a1s = ack1;
    end
    step(); req0 = 0; req1 = 0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
